iir_out_fifo: RTL and testbench

IIR_OUT_FIFO -- requirements
Module: iir_out_fifo

---
 rtl/iir_pkg.sv | 18 +
 rtl/iir_fifo_mem.sv | 27 ++
 rtl/iir_out_fifo.sv | 151 +++++++++++++++
 tb/tb_iir_out_fifo.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// Shared constants and helpers for the IIR output capture path.
package iir_pkg;

    localparam int unsigned SAMPLE_W      = 16;
    localparam int unsigned FRAC_BITS     = 11;
    localparam int unsigned DEFAULT_DEPTH = 16;
    localparam int unsigned DROP_CNT_W    = 8;
    localparam int unsigned DROP_CNT_MAX  = (1 << DROP_CNT_W) - 1;

    // Signed Q5.11 filter sample; stored verbatim, never rescaled.
    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Saturating increment used by the drop counter.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == DROP_CNT_W'(DROP_CNT_MAX)) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/iir_fifo_mem.sv
// FIFO sample storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the controller's pointers define validity.
module iir_fifo_mem
    import iir_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [SAMPLE_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [SAMPLE_W-1:0]        rdata
);

    sample_t mem_q [DEPTH];

    // Write port: store the captured sample at the write pointer.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/iir_out_fifo.sv
// Decimating capture FIFO for IIR filter outputs with first-word-fall-through
// streaming output, sticky overflow flag and an optional saturating drop counter.
// Optional feature: define IIR_OUT_DROP_CNT_EN to build the drop counter;
// otherwise drop_count is tied to zero.
module iir_out_fifo
    import iir_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned DECIM = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [SAMPLE_W-1:0]       y_in,
    input  logic                      y_strobe,
    output logic [SAMPLE_W-1:0]       m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    output logic [DROP_CNT_W-1:0]     drop_count,
    input  logic                      clear_ovf
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [CNT_W-1:0]    dec_cnt_q, dec_cnt_d;
    logic [PTR_W-1:0]    wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q,  rd_ptr_d;
    logic [LVL_W-1:0]    level_q,   level_d;
    logic                valid_q,   valid_d;
    logic                overflow_q, overflow_d;

    logic                capture_c;
    logic                pop_c;
    logic                full_c;
    logic                push_c;
    logic                drop_c;
    logic [SAMPLE_W-1:0] rd_data;

    // Storage array; write on accepted capture, read at the head pointer.
    iir_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push_c),
        .waddr (wr_ptr_q),
        .wdata (y_in),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    // Handshake and capture qualification; a pop frees a slot for a same-cycle push.
    always_comb begin
        capture_c = y_strobe & en & (dec_cnt_q == CNT_W'(DECIM - 1));
        pop_c     = valid_q & m_ready;
        full_c    = (level_q == LVL_W'(DEPTH));
        push_c    = capture_c & (~full_c | pop_c);
        drop_c    = capture_c & full_c & ~pop_c;
    end

    // Decimation counter: counts enabled strobes, wraps on capture, clears while disabled.
    always_comb begin
        dec_cnt_d = dec_cnt_q;
        if (!en) begin
            dec_cnt_d = '0;
        end else if (y_strobe) begin
            dec_cnt_d = capture_c ? '0 : dec_cnt_q + CNT_W'(1);
        end
    end

    // Pointer, occupancy and flag next-state; pointers wrap naturally at power-of-two DEPTH.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        level_d = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
        if (clear_ovf) begin
            overflow_d = drop_c;
        end else if (drop_c) begin
            overflow_d = 1'b1;
        end
    end

    // Valid tracks the next occupancy so a capture is visible one cycle later.
    always_comb begin
        valid_d = (level_d != '0);
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            dec_cnt_q  <= dec_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef IIR_OUT_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // Drop counter: saturating; a drop coinciding with clear leaves a count of one.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clear_ovf) begin
            drop_cnt_d = drop_c ? DROP_CNT_W'(1) : '0;
        end else if (drop_c) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
        end
    end

    // Drop counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = '0;
`endif

    // Head data is gated by valid so an empty or resetting FIFO presents zero.
    assign m_data   = valid_q ? rd_data : '0;
    assign m_valid  = valid_q;
    assign level    = level_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_iir_out_fifo.sv
// Bench for iir_out_fifo: two instances (DECIM=1 and DECIM=4) share stimulus.
// A reference model pushes expected samples into per-instance scoreboards and a
// negedge monitor pops and compares whenever the DUT presents a handshake.
module tb_iir_out_fifo;

    localparam int DEPTH = 16;
`ifdef IIR_OUT_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [15:0] y_in = '0;
    logic        y_strobe = 1'b0;
    logic        m_ready = 1'b0;
    logic        clear_ovf = 1'b0;

    logic [15:0] m_data_w  [2];
    logic        m_valid_w [2];
    logic [4:0]  level_w   [2];
    logic        ovf_w     [2];
    logic [7:0]  drop_w    [2];

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    logic [15:0] sb_q [2][$];
    int          dec [2] = '{1, 4};
    int          ns [2];
    int          drop_m [2];
    bit          ovf_m [2];
    bit          popped [2];

    always #5 clk = ~clk;

    iir_out_fifo #(.DEPTH(DEPTH), .DECIM(1)) u_dut_d1 (
        .clk(clk), .reset(reset), .en(en), .y_in(y_in), .y_strobe(y_strobe),
        .m_data(m_data_w[0]), .m_valid(m_valid_w[0]), .m_ready(m_ready),
        .level(level_w[0]), .overflow(ovf_w[0]), .drop_count(drop_w[0]),
        .clear_ovf(clear_ovf)
    );

    iir_out_fifo #(.DEPTH(DEPTH), .DECIM(4)) u_dut_d4 (
        .clk(clk), .reset(reset), .en(en), .y_in(y_in), .y_strobe(y_strobe),
        .m_data(m_data_w[1]), .m_valid(m_valid_w[1]), .m_ready(m_ready),
        .level(level_w[1]), .overflow(ovf_w[1]), .drop_count(drop_w[1]),
        .clear_ovf(clear_ovf)
    );

    task automatic chk(input string name, input int k, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, k, act, exp, $time);
        end
    endtask

    function automatic int exp_drop(input int v);
        return DROP_EN ? v : 0;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            sb_q[k].delete();
            ns[k]     = 0;
            drop_m[k] = 0;
            ovf_m[k]  = 1'b0;
            popped[k] = 1'b0;
        end
    endtask

    // Reference model: every DECIM-th enabled strobe since enable/reset is a capture;
    // captures into a full FIFO are dropped unless the head leaves on the same edge.
    always @(posedge clk) begin
        int occ;
        bit cap;
        bit drp;
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                occ = sb_q[k].size() + (popped[k] ? 1 : 0);
                cap = 1'b0;
                if (!en) begin
                    ns[k] = 0;
                end else if (y_strobe) begin
                    ns[k] = ns[k] + 1;
                    cap   = (ns[k] % dec[k]) == 0;
                end
                drp = cap && (occ >= DEPTH) && !popped[k];
                if (cap && !drp) sb_q[k].push_back(y_in);
                if (clear_ovf) begin
                    ovf_m[k]  = drp;
                    drop_m[k] = drp ? 1 : 0;
                end else if (drp) begin
                    ovf_m[k] = 1'b1;
                    if (drop_m[k] < 255) drop_m[k] = drop_m[k] + 1;
                end
                popped[k] = 1'b0;
            end
        end
    end

    // Monitor: compare presented outputs and pop the scoreboard on a handshake.
    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                chk("m_valid", k, int'(m_valid_w[k]), int'(sb_q[k].size() > 0));
                chk("level", k, int'(level_w[k]), sb_q[k].size());
                if (sb_q[k].size() > 0) begin
                    chk("m_data", k, int'(m_data_w[k]), int'(sb_q[k][0]));
                    if (m_ready) begin
                        void'(sb_q[k].pop_front());
                        popped[k] = 1'b1;
                    end
                end
                chk("overflow", k, int'(ovf_w[k]), int'(ovf_m[k]));
                chk("drop_count", k, int'(drop_w[k]), exp_drop(drop_m[k]));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit e, input bit s, input logic [15:0] y, input bit r, input bit c);
        en        = e;
        y_strobe  = s;
        y_in      = y;
        m_ready   = r;
        clear_ovf = c;
        cyc();
    endtask

    task automatic chk_reset_state();
        for (int k = 0; k < 2; k++) begin
            chk("rst_m_valid", k, int'(m_valid_w[k]), 0);
            chk("rst_level", k, int'(level_w[k]), 0);
            chk("rst_m_data", k, int'(m_data_w[k]), 0);
            chk("rst_overflow", k, int'(ovf_w[k]), 0);
            chk("rst_drop_count", k, int'(drop_w[k]), 0);
        end
    endtask

    task automatic basic_seq();
        drive(1, 1, 16'h0800, 1, 0);
        drive(1, 1, 16'h1000, 1, 0);
        drive(1, 1, 16'hF800, 1, 0);
        repeat (4) drive(1, 0, 16'h0000, 1, 0);
    endtask

    initial begin
        // Reset state
        #12;
        chk_reset_state();
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();

        // Three strobes with DECIM=1 streaming straight through
        basic_seq();

        // Decimation by four, with an enable gap after strobe 6
        drive(0, 0, 16'h0000, 1, 0);
        for (int i = 1; i <= 6; i++) drive(1, 1, 16'(i), 1, 0);
        drive(0, 0, 16'h0000, 1, 0);
        for (int i = 7; i <= 12; i++) drive(1, 1, 16'(i), 1, 0);
        repeat (4) drive(1, 0, 16'h0000, 1, 0);

        // Fill with 20 captures while stalled: 4 drops, head held
        repeat (3) drive(0, 0, 16'h0000, 1, 0);
        for (int i = 0; i < 20; i++) drive(1, 1, 16'(16'h0100 + i), 0, 0);
        chk("full_level", 0, int'(level_w[0]), 16);
        chk("full_overflow", 0, int'(ovf_w[0]), 1);
        chk("full_drop_count", 0, int'(drop_w[0]), exp_drop(4));
        chk("full_head", 0, int'(m_data_w[0]), 16'h0100);
        drive(1, 0, 16'h0000, 0, 1);
        chk("clear_overflow", 0, int'(ovf_w[0]), 0);
        chk("clear_drop_count", 0, int'(drop_w[0]), 0);

        // Full FIFO with capture and pop on the same edge
        drive(1, 1, 16'h7ABC, 1, 0);
        chk("pushpop_level", 0, int'(level_w[0]), 16);
        chk("pushpop_drop_count", 0, int'(drop_w[0]), 0);
        chk("pushpop_overflow", 0, int'(ovf_w[0]), 0);
        repeat (20) drive(1, 0, 16'h0000, 1, 0);

        // Saturation: 16 fills then 300 drops
        for (int i = 0; i < 316; i++) drive(1, 1, 16'(16'h3000 + i), 0, 0);
        chk("sat_drop_count", 0, int'(drop_w[0]), exp_drop(255));
        chk("sat_overflow", 0, int'(ovf_w[0]), 1);
        drive(1, 0, 16'h0000, 1, 1);
        repeat (20) drive(1, 0, 16'h0000, 1, 0);

        // Reset mid-stream with seven entries stored
        for (int i = 0; i < 7; i++) drive(1, 1, 16'(16'h0200 + i), 0, 0);
        chk("pre_rst_level", 0, int'(level_w[0]), 7);
        reset = 1'b1;
        model_clear();
        #1;
        chk_reset_state();
        cyc();
        cyc();
        reset = 1'b0;
        model_clear();
        basic_seq();

        // Randomized traffic with varying backpressure
        for (int blk = 0; blk < 6; blk++) begin
            for (int i = 0; i < 500; i++) begin
                bit e, s, r, c;
                e = ($urandom % 10) != 0;
                s = ($urandom % 3) != 0;
                r = ($urandom % 8) < (2 + blk);
                c = ($urandom % 60) == 0;
                drive(e, s, 16'($urandom), r, c);
            end
        end
        repeat (30) drive(0, 0, 16'h0000, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
